led_blink_scheduler: RTL and testbench
======================================

# led_blink_scheduler

Shares the single status LED between several requesters. Each requester asks for a burst of N blinks, and a round-robin arbiter picks one. The block then sequences the LED through on/off phases of a fixed half-period, followed by an inter-burst gap, and signals completion. It sits between the status sources and the board LED pin, and takes over from a free-running blinker.

## Interface
Parameters:
- HALF_PERIOD, 25000000: cycles per ON or OFF phase; must be >= 1.
- GAP_PHASES, 2: number of HALF_PERIOD-long dark phases after each burst; 0 allowed.
- NREQ, 4: number of requesters; must be >= 2.
- CNT_W, 4: width of each blink-count field.

Ports:
- clkin  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req  in  NREQ  level request per requester.
- req_count  in  NREQ*CNT_W  blink count; requester i uses bits [i*CNT_W +: CNT_W].
- grant  out  NREQ  one-hot; names the requester owning the LED.
- done  out  NREQ  one-cycle pulse when that requester's burst ends.
- busy  out  1  high when state is not IDLE.
- outled  out  1  LED drive, registered.

## Operation
- States: IDLE, ON, OFF, GAP.
- Reset (rst_n low at an edge) forces:
  - state IDLE; outled, grant, done, busy all 0;
  - phase timer 0, remaining-count 0;
  - round-robin pointer 0, so requester 0 has top priority first.
- IDLE:
  - Round-robin over req, starting at the pointer. The pointer then moves to granted index + 1 (mod NREQ).
  - On a winner: latch its req_count into remaining and set grant one-hot.
  - If the latched count is nonzero: go to ON, outled = 1.
  - If the latched count is 0: grant is high for one cycle, done pulses on the next cycle, state stays IDLE, outled stays 0.
- Phase timer:
  - Counts 0..HALF_PERIOD-1.
  - Phase end = timer at HALF_PERIOD-1; the timer then clears.
  - The timer is 32 bits, unsigned, and never wraps otherwise.
- ON: at phase end go to OFF, outled = 0, and decrement remaining.
- OFF: at phase end:
  - remaining != 0: go to ON, outled = 1.
  - remaining == 0 and GAP_PHASES > 0: go to GAP.
  - otherwise: finish.
- GAP: outled held 0. A gap counter counts phase ends; after GAP_PHASES of them, finish.
- Finish: state IDLE, grant = 0, and done[granted] pulses one cycle in that same cycle.
- The burst is non-preemptive. If req drops mid-burst, the burst still completes and done still pulses.
- req_count is sampled only at grant.
- A requester that keeps req high after done is eligible again, but rotation serves the others first.
- busy = (state != IDLE).

## Timing
- Grant latency: req high in IDLE at edge T gives grant and outled = 1 registered at T+1.
- Burst of N blinks: done pulses (2N + GAP_PHASES) * HALF_PERIOD cycles after grant rises. grant falls in the same cycle.
- Next grant is at least 1 cycle after done, because IDLE always lasts at least one cycle.
- Zero count: grant at T+1, done at T+2.
- Simultaneous requests: exactly one grant per arbitration, chosen by pointer order.
- Reset mid-operation: all outputs 0 at the next edge, and no done pulse is issued.

## Structure
- Package led_sched_pkg holds:
  - the state enum (IDLE/ON/OFF/GAP);
  - the timer width constant (32);
  - the default HALF_PERIOD and GAP_PHASES.
- Sub-module rr_arbiter (parameter NREQ): takes req and the pointer, returns a one-hot winner and a valid flag. It is pure combinational; the pointer register stays in the parent.
- The FSM, phase timer, remaining counter and gap counter live in led_blink_scheduler.

## Test plan
All scenarios use HALF_PERIOD=4, GAP_PHASES=1, NREQ=4, CNT_W=4.
- Reset: rst_n low for 3 cycles with req=4'b1111 and all counts 5 -> outled, grant, done, busy all 0 throughout; after release, grant=4'b0001 at the next edge.
- Single burst: req[2]=1, count=3 -> grant=4'b0100 one cycle later; outled pattern 1111 0000 repeated three times, then 0000 gap; done[2] pulses 28 cycles after grant rises, with grant low in that cycle.
- Round-robin: req=4'b0011 held, counts 1 -> grants go 0001, 0010, 0001, 0010; each burst is 12 cycles, with at least 1 idle cycle between bursts.
- Zero count: req[1]=1, count=0 -> grant=4'b0010 for one cycle, done[1] on the next cycle, outled stays 0, busy stays 0.
- Reset mid-burst: rst_n low during the second ON phase -> outled and grant are 0 at the next edge, done never pulses, state is IDLE.
- Req drop: req[3] deasserted 5 cycles into a count=2 burst -> the burst still runs its full 20 cycles and done[3] pulses.

Source files
------------

// File: rtl/led_sched_pkg.sv
// Shared types and constants for the LED blink scheduler.
package led_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // Phase timer and gap counter width.
  localparam int TIMER_W = 32;

  localparam int DEFAULT_HALF_PERIOD = 25000000;
  localparam int DEFAULT_GAP_PHASES  = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after the
// pointer (wrapping) wins. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic             vld_o
);

  // Scan requesters in rotated order and keep only the first hit.
  always_comb begin
    gnt_o = '0;
    vld_o = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!vld_o && req_i[(int'(ptr_i) + k) % NREQ]) begin
        gnt_o[(int'(ptr_i) + k) % NREQ] = 1'b1;
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_blink_scheduler.sv
// Shares one status LED between NREQ requesters: round-robin grant, then
// N on/off blinks of HALF_PERIOD cycles each, a dark gap, and a done pulse.
module led_blink_scheduler
  import led_sched_pkg::*;
#(
  parameter int HALF_PERIOD = DEFAULT_HALF_PERIOD,
  parameter int GAP_PHASES  = DEFAULT_GAP_PHASES,
  parameter int NREQ        = 4,
  parameter int CNT_W       = 4
) (
  input  logic                  clkin,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CNT_W-1:0] req_count,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  outled
);

  localparam int PTR_W = $clog2(NREQ);

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [TIMER_W-1:0]   gap_q, gap_d;
  logic [CNT_W-1:0]     rem_q, rem_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]      grant_q, grant_d;
  logic [NREQ-1:0]      done_q, done_d;
  logic                 outled_q, outled_d;

  logic [NREQ-1:0]      arb_gnt;
  logic                 arb_vld;
  int                   win_idx;
  logic [CNT_W-1:0]     win_cnt;
  logic                 phase_end;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .vld_o (arb_vld)
  );

  // Convert the one-hot winner to an index to pick its count field.
  always_comb begin
    win_idx = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) win_idx = i;
    end
  end

  assign win_cnt   = req_count[win_idx*CNT_W +: CNT_W];
  assign phase_end = (timer_q == TIMER_W'(HALF_PERIOD - 1));

  // Next-state and output logic; a finished burst returns straight to IDLE
  // with grant cleared and done naming the former owner.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    gap_d    = gap_q;
    rem_d    = rem_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    done_d   = '0;
    outled_d = outled_q;

    unique case (state_q)
      ST_IDLE: begin
        timer_d  = '0;
        gap_d    = '0;
        outled_d = 1'b0;
        if (grant_q != '0) begin
          // Zero-count grant: close it out before arbitrating again.
          done_d  = grant_q;
          grant_d = '0;
        end else if (arb_vld) begin
          grant_d = arb_gnt;
          ptr_d   = PTR_W'((win_idx + 1) % NREQ);
          rem_d   = win_cnt;
          if (win_cnt != '0) begin
            state_d  = ST_ON;
            outled_d = 1'b1;
          end
        end
      end

      ST_ON: begin
        timer_d = phase_end ? '0 : timer_q + 1'b1;
        if (phase_end) begin
          state_d  = ST_OFF;
          outled_d = 1'b0;
          rem_d    = rem_q - 1'b1;
        end
      end

      ST_OFF: begin
        timer_d = phase_end ? '0 : timer_q + 1'b1;
        if (phase_end) begin
          if (rem_q != '0) begin
            state_d  = ST_ON;
            outled_d = 1'b1;
          end else if (GAP_PHASES > 0) begin
            state_d = ST_GAP;
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
            done_d  = grant_q;
          end
        end
      end

      ST_GAP: begin
        timer_d  = phase_end ? '0 : timer_q + 1'b1;
        outled_d = 1'b0;
        if (phase_end) begin
          if (gap_q == TIMER_W'(GAP_PHASES - 1)) begin
            state_d = ST_IDLE;
            grant_d = '0;
            done_d  = grant_q;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      gap_q    <= '0;
      rem_q    <= '0;
      ptr_q    <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      outled_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      gap_q    <= gap_d;
      rem_q    <= rem_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      outled_q <= outled_d;
    end
  end

  assign grant  = grant_q;
  assign done   = done_q;
  assign outled = outled_q;
  assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Bench for led_blink_scheduler with HALF_PERIOD=4, GAP_PHASES=1, NREQ=4.
// The reference model tracks each burst by its start cycle and derives the
// LED level and done time arithmetically from the blink count.
module tb_led_blink_scheduler;

  localparam int HP = 4;
  localparam int GP = 1;
  localparam int NR = 4;
  localparam int CW = 4;
  localparam int OW = 2*NR + 2;

  logic             clkin = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req;
  logic [NR*CW-1:0] req_count;
  logic [NR-1:0]    grant;
  logic [NR-1:0]    done;
  logic             busy;
  logic             outled;

  always #5 clkin = ~clkin;

  led_blink_scheduler #(
    .HALF_PERIOD (HP),
    .GAP_PHASES  (GP),
    .NREQ        (NR),
    .CNT_W       (CW)
  ) dut (
    .clkin     (clkin),
    .rst_n     (rst_n),
    .req       (req),
    .req_count (req_count),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .outled    (outled)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  longint        cyc = 0;
  longint        m_start;
  int            m_owner;
  int            m_zero;
  int            m_ptr;
  int            m_n;
  logic [NR-1:0] e_grant, e_done;
  logic          e_busy, e_led;

  task automatic model_step(input logic rn, input logic [NR-1:0] r,
                            input logic [NR*CW-1:0] c);
    int e;
    int idx;
    cyc++;
    e_done = '0;
    if (!rn) begin
      m_owner = -1; m_zero = -1; m_ptr = 0;
      e_grant = '0; e_busy = 1'b0; e_led = 1'b0;
    end else if (m_owner >= 0) begin
      e = int'(cyc - m_start);
      if (e == (2*m_n + GP)*HP) begin
        e_done[m_owner] = 1'b1;
        m_owner = -1;
        e_grant = '0; e_busy = 1'b0; e_led = 1'b0;
      end else begin
        e_led = (e < 2*m_n*HP) && ((e / HP) % 2 == 0);
      end
    end else if (m_zero >= 0) begin
      e_done[m_zero] = 1'b1;
      m_zero = -1;
      e_grant = '0;
    end else begin
      idx = -1;
      for (int k = 0; k < NR; k++)
        if (idx < 0 && r[(m_ptr + k) % NR]) idx = (m_ptr + k) % NR;
      e_grant = '0; e_busy = 1'b0; e_led = 1'b0;
      if (idx >= 0) begin
        m_ptr = (idx + 1) % NR;
        m_n = int'(c[idx*CW +: CW]);
        e_grant[idx] = 1'b1;
        if (m_n == 0) m_zero = idx;
        else begin
          m_owner = idx; m_start = cyc; e_busy = 1'b1; e_led = 1'b1;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clkin);
    model_step(rst_n, req, req_count);
    #1;
  endtask

  function automatic logic [OW-1:0] act_o();
    return {grant, done, busy, outled};
  endfunction

  function automatic logic [OW-1:0] exp_o();
    return {e_grant, e_done, e_busy, e_led};
  endfunction

  // Run until the model is idle with nothing pending; bounded.
  task automatic drain();
    int n;
    n = 0;
    while ((m_owner >= 0 || m_zero >= 0 || e_done != '0) && n < 400) begin
      cycle();
      n++;
    end
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL drain_timeout: model still busy after %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = '1;
    req_count = {NR{4'd5}};
    repeat (3) begin
      cycle();
      checks++;
      if (act_o() !== '0) begin
        errors++;
        $display("FAIL reset_hold: got g/d/b/l=%b want all zero", act_o());
      end
    end
    rst_n = 1'b1;
    cycle();
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant: got %b want 0001", grant);
    end
    req = '0;
    drain();
  endtask

  task automatic test_single_burst();
    req = 4'b0100;
    req_count = 16'h0300;
    cycle();
    checks++;
    if (grant !== 4'b0100 || outled !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: got grant=%b led=%b want 0100 1", grant, outled);
    end
    req = '0;
    for (int i = 1; i <= 28; i++) begin
      cycle();
      checks++;
      if (act_o() !== exp_o()) begin
        errors++;
        $display("FAIL single_burst t=%0d: got %b want %b", i, act_o(), exp_o());
      end
    end
    checks++;
    if (done !== 4'b0100 || grant !== 4'b0000) begin
      errors++;
      $display("FAIL single_done: got done=%b grant=%b want 0100 0000", done, grant);
    end
    drain();
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] want [4];
    logic [NR-1:0] prev;
    longint        rise, last_done;
    int            n, guard;
    want = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
    req = 4'b0011;
    req_count = 16'h1111;
    prev = '0; n = 0; guard = 0; rise = 0; last_done = -10;
    while (n < 4 && guard < 200) begin
      cycle();
      guard++;
      checks++;
      if (act_o() !== exp_o()) begin
        errors++;
        $display("FAIL rr_cycle c=%0d: got %b want %b", cyc, act_o(), exp_o());
      end
      if (done != '0) begin
        checks++;
        if (cyc - rise != 12) begin
          errors++;
          $display("FAIL rr_burst_len: got %0d want 12", cyc - rise);
        end
        last_done = cyc;
        n++;
      end
      if (grant != '0 && prev == '0) begin
        checks++;
        if (grant !== want[n] || cyc - last_done < 1) begin
          errors++;
          $display("FAIL rr_order #%0d: got %b want %b gap=%0d", n, grant, want[n], cyc - last_done);
        end
        rise = cyc;
      end
      prev = grant;
    end
    if (n < 4) begin
      checks++; errors++;
      $display("FAIL rr_timeout: got %0d bursts want 4", n);
    end
    req = '0;
    drain();
  endtask

  task automatic test_zero_count();
    req = 4'b0010;
    req_count = 16'h0000;
    cycle();
    checks++;
    if (grant !== 4'b0010 || busy !== 1'b0 || outled !== 1'b0 || done !== 4'b0000) begin
      errors++;
      $display("FAIL zero_grant: got g=%b b=%b l=%b d=%b want 0010 0 0 0000", grant, busy, outled, done);
    end
    req = '0;
    cycle();
    checks++;
    if (done !== 4'b0010 || grant !== 4'b0000 || busy !== 1'b0 || outled !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: got d=%b g=%b b=%b l=%b want 0010 0000 0 0", done, grant, busy, outled);
    end
    drain();
  endtask

  task automatic test_reset_mid_burst();
    req = 4'b0001;
    req_count = 16'h0003;
    cycle();
    req = '0;
    for (int i = 1; i <= 9; i++) cycle();
    checks++;
    if (outled !== 1'b1) begin
      errors++;
      $display("FAIL midrst_second_on: got led=%b want 1", outled);
    end
    rst_n = 1'b0;
    cycle();
    checks++;
    if (act_o() !== '0) begin
      errors++;
      $display("FAIL midrst_clear: got %b want all zero", act_o());
    end
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      checks++;
      if (done !== '0 || busy !== 1'b0 || act_o() !== exp_o()) begin
        errors++;
        $display("FAIL midrst_after t=%0d: got %b want %b", i, act_o(), exp_o());
      end
    end
  endtask

  task automatic test_req_drop();
    req = 4'b1000;
    req_count = 16'h2000;
    cycle();
    checks++;
    if (grant !== 4'b1000) begin
      errors++;
      $display("FAIL drop_grant: got %b want 1000", grant);
    end
    for (int i = 1; i <= 20; i++) begin
      if (i == 6) req = '0;
      cycle();
      checks++;
      if (act_o() !== exp_o()) begin
        errors++;
        $display("FAIL drop_burst t=%0d: got %b want %b", i, act_o(), exp_o());
      end
    end
    checks++;
    if (done !== 4'b1000 || grant !== 4'b0000) begin
      errors++;
      $display("FAIL drop_done: got done=%b grant=%b want 1000 0000", done, grant);
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) req = NR'($urandom);
      req_count = (NR*CW)'($urandom) & 16'h3333;
      rst_n = ($urandom_range(0, 299) != 0);
      cycle();
      checks++;
      if (act_o() !== exp_o()) begin
        errors++;
        $display("FAIL random c=%0d: got %b want %b", cyc, act_o(), exp_o());
      end
    end
    rst_n = 1'b1;
    req = '0;
    drain();
  endtask

  initial begin
    m_owner = -1; m_zero = -1; m_ptr = 0; m_n = 0; m_start = 0;
    e_grant = '0; e_done = '0; e_busy = 1'b0; e_led = 1'b0;
    rst_n = 1'b0; req = '0; req_count = '0;
    #1;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_zero_count();
    test_reset_mid_burst();
    test_req_drop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
